// File: rtl/ad9517_spi_master.sv
// SPI mode-0 master for AD9517 register access: one 24-bit frame per command
// (16-bit instruction then 8-bit data), read byte returned with a one-cycle valid.
`timescale 1ns/1ps
module ad9517_spi_master #(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int CLK_DIV         = 4,
    parameter int CS_IDLE         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_spi_wr_cmd,
    input  logic                       i_spi_rd_cmd,
    input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
    output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
    output logic                       o_spi_rd_valid,
    output logic                       o_spi_busy,
    output logic                       o_spi_sclk,
    output logic                       o_spi_csb,
    output logic                       o_spi_sdio,
    output logic                       o_spi_sdio_oe,
    input  logic                       i_spi_miso
);

    localparam int HC_W  = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_IDLE + 1);
    localparam int INS_W = MOSI_DATA_WIDTH - MISO_DATA_WIDTH;
    localparam logic [HC_W-1:0]  HC_LAST   = HC_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_IDLE - 1);
    localparam logic [4:0]       BIT_TOP   = 5'(MOSI_DATA_WIDTH - 1);
    localparam logic [4:0]       DATA_LAST = 5'(MISO_DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HI, S_LO, S_GAP} state_t;

    state_t                     state, state_nxt;
    logic [HC_W-1:0]            hc_cnt;
    logic [GAP_W-1:0]           gap_cnt;
    logic [4:0]                 bit_cnt;
    logic                       last_bit;
    logic                       is_read;
    logic [MOSI_DATA_WIDTH-1:0] shift_reg;
    logic [MISO_DATA_WIDTH-1:0] capture;
    logic                       accept;
    logic                       hc_end;
    logic                       in_frame;

    assign accept   = (state == S_IDLE) && (i_spi_wr_cmd || i_spi_rd_cmd);
    assign hc_end   = (hc_cnt == HC_LAST);
    assign in_frame = (state == S_SETUP) || (state == S_HI) || (state == S_LO);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SETUP;
            S_SETUP: if (hc_end) state_nxt = S_HI;
            S_HI:    if (hc_end) state_nxt = S_LO;
            S_LO:    if (hc_end) state_nxt = last_bit ? S_GAP : S_HI;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pins decode straight from the state register; the LO after bit 0 is the CSB hold.
    always_comb begin
        o_spi_busy    = (state != S_IDLE);
        o_spi_sclk    = (state == S_HI);
        o_spi_csb     = !in_frame;
        o_spi_sdio    = (in_frame && !last_bit) ? shift_reg[MOSI_DATA_WIDTH-1] : 1'b0;
        o_spi_sdio_oe = !(is_read && ((state == S_HI) || (state == S_LO)) && (bit_cnt <= DATA_LAST));
    end

    // Control stage: FSM, counters and read-result handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            hc_cnt         <= '0;
            gap_cnt        <= '0;
            bit_cnt        <= '0;
            last_bit       <= 1'b0;
            is_read        <= 1'b0;
            o_spi_rd_valid <= 1'b0;
            o_spi_rd_data  <= '0;
        end else begin
            state          <= state_nxt;
            hc_cnt         <= (!in_frame || hc_end) ? '0 : hc_cnt + HC_W'(1);
            gap_cnt        <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            o_spi_rd_valid <= 1'b0;
            if (accept) begin
                bit_cnt  <= BIT_TOP;
                last_bit <= 1'b0;
                is_read  <= i_spi_rd_cmd;
            end
            if (state == S_HI && hc_end) begin
                if (bit_cnt == 5'd0) last_bit <= 1'b1;
                else                 bit_cnt  <= bit_cnt - 5'd1;
            end
            if (state == S_LO && hc_end && last_bit && is_read) begin
                o_spi_rd_valid <= 1'b1;
                o_spi_rd_data  <= capture;
            end
        end
    end

    // Data stage: transmit shifter and receive capture, no reset needed.
    always_ff @(posedge clk) begin
        if (accept)
            shift_reg <= {i_spi_wr_data[INS_W-1:0], i_spi_wr_data[MOSI_DATA_WIDTH-1:INS_W]};
        else if (state == S_HI && hc_end)
            shift_reg <= {shift_reg[MOSI_DATA_WIDTH-2:0], 1'b0};
        if (state == S_HI && hc_end)
            capture <= {capture[MISO_DATA_WIDTH-2:0], i_spi_miso};
    end

endmodule

// File: tb/tb_ad9517_spi_master.sv
// Directed bench for ad9517_spi_master: default timing instance plus a CLK_DIV=2/CS_IDLE=1 instance.
`timescale 1ns/1ps
module tb_ad9517_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr0, rd0, wr1, rd1;
    logic [23:0] wd0, wd1;
    logic        miso;
    logic [7:0]  rdd0, rdd1;
    logic        vld0, vld1, busy0, busy1, sclk0, sclk1, csb0, csb1, sdio0, sdio1, oe0, oe1;

    int          tests = 0;
    int          fails = 0;

    int          busy_cnt, rises, vld_cnt;
    int          rise_cyc [2];
    logic [23:0] mosi, oe_vec;
    logic [7:0]  vld_data, slave_byte;
    logic        vld_csb, timeout, busy_at_accept;

    always #5 clk = ~clk;

    ad9517_spi_master dut0 (
        .clk(clk), .rst(rst), .i_spi_wr_cmd(wr0), .i_spi_rd_cmd(rd0), .i_spi_wr_data(wd0),
        .o_spi_rd_data(rdd0), .o_spi_rd_valid(vld0), .o_spi_busy(busy0), .o_spi_sclk(sclk0),
        .o_spi_csb(csb0), .o_spi_sdio(sdio0), .o_spi_sdio_oe(oe0), .i_spi_miso(miso)
    );

    ad9517_spi_master #(.CLK_DIV(2), .CS_IDLE(1)) dut1 (
        .clk(clk), .rst(rst), .i_spi_wr_cmd(wr1), .i_spi_rd_cmd(rd1), .i_spi_wr_data(wd1),
        .o_spi_rd_data(rdd1), .o_spi_rd_valid(vld1), .o_spi_busy(busy1), .o_spi_sclk(sclk1),
        .o_spi_csb(csb1), .o_spi_sdio(sdio1), .o_spi_sdio_oe(oe1), .i_spi_miso(miso)
    );

    // One-cycle command, then observe the frame on falling clk edges; slave drives data-phase MISO.
    task automatic run_frame(input bit sel, input logic wr, input logic rd, input logic [23:0] data);
        logic prev_sclk, s_sclk, s_busy;
        int   idx;
        @(negedge clk);
        if (sel) begin wr1 = wr; rd1 = rd; wd1 = data; end
        else     begin wr0 = wr; rd0 = rd; wd0 = data; end
        busy_at_accept = sel ? busy1 : busy0;
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        busy_cnt = 0; rises = 0; vld_cnt = 0; mosi = '0; oe_vec = '0;
        vld_data = '0; vld_csb = 1'b0; rise_cyc[0] = 0; rise_cyc[1] = 0;
        prev_sclk = 1'b0;
        s_busy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s_busy = sel ? busy1 : busy0;
            s_sclk = sel ? sclk1 : sclk0;
            if (!s_busy) break;
            busy_cnt++;
            if (s_sclk && !prev_sclk) begin
                mosi   = {mosi[22:0], (sel ? sdio1 : sdio0)};
                oe_vec = {oe_vec[22:0], (sel ? oe1 : oe0)};
                if (rises < 2) rise_cyc[rises] = i;
                rises++;
            end
            if (!s_sclk && prev_sclk && rises >= 16 && rises < 24) begin
                idx  = 7 - (rises - 16);
                miso = slave_byte[idx];
            end
            if (sel ? vld1 : vld0) begin
                vld_cnt++;
                vld_data = sel ? rdd1 : rdd0;
                vld_csb  = sel ? csb1 : csb0;
            end
            prev_sclk = s_sclk;
            @(negedge clk);
        end
        timeout = sel ? busy1 : busy0;
        miso = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0; wd0 = '0; wd1 = '0; miso = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (csb0 !== 1'b1)   begin fails++; $display("FAIL reset_csb got %b exp 1", csb0); end
        tests++; if (sclk0 !== 1'b0)  begin fails++; $display("FAIL reset_sclk got %b exp 0", sclk0); end
        tests++; if (busy0 !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b exp 0", busy0); end
        tests++; if (oe0 !== 1'b1)    begin fails++; $display("FAIL reset_oe got %b exp 1", oe0); end
        tests++; if (sdio0 !== 1'b0)  begin fails++; $display("FAIL reset_sdio got %b exp 0", sdio0); end
        tests++; if (rdd0 !== 8'h00)  begin fails++; $display("FAIL reset_rd_data got %h exp 00", rdd0); end
        tests++; if (vld0 !== 1'b0)   begin fails++; $display("FAIL reset_rd_valid got %b exp 0", vld0); end
        tests++; if ({csb1, busy1} !== 2'b10) begin fails++; $display("FAIL reset_fast got csb,busy=%b exp 10", {csb1, busy1}); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        slave_byte = 8'hFF;
        run_frame(1'b0, 1'b1, 1'b0, 24'h5A0010);
        tests++; if (busy_at_accept !== 1'b0) begin fails++; $display("FAIL wr_busy_accept got %b exp 0", busy_at_accept); end
        tests++; if (timeout !== 1'b0)  begin fails++; $display("FAIL wr_timeout busy still %b", timeout); end
        tests++; if (busy_cnt != 200)   begin fails++; $display("FAIL wr_busy_len got %0d exp 200", busy_cnt); end
        tests++; if (rises != 24)       begin fails++; $display("FAIL wr_rises got %0d exp 24", rises); end
        tests++; if (mosi !== 24'h00105A) begin fails++; $display("FAIL wr_mosi got %h exp 00105a", mosi); end
        tests++; if (oe_vec !== 24'hFFFFFF) begin fails++; $display("FAIL wr_oe got %h exp ffffff", oe_vec); end
        tests++; if (vld_cnt != 0)      begin fails++; $display("FAIL wr_rd_valid got %0d pulses exp 0", vld_cnt); end
        tests++; if (rise_cyc[1] - rise_cyc[0] != 8) begin fails++; $display("FAIL wr_sclk_period got %0d exp 8", rise_cyc[1] - rise_cyc[0]); end
    endtask

    task automatic test_read();
        slave_byte = 8'h53;
        run_frame(1'b0, 1'b0, 1'b1, 24'h008003);
        tests++; if (busy_cnt != 200)   begin fails++; $display("FAIL rd_busy_len got %0d exp 200", busy_cnt); end
        tests++; if (mosi[23:8] !== 16'h8003) begin fails++; $display("FAIL rd_mosi got %h exp 8003", mosi[23:8]); end
        tests++; if (oe_vec !== 24'hFFFF00) begin fails++; $display("FAIL rd_oe got %h exp ffff00", oe_vec); end
        tests++; if (vld_cnt != 1)      begin fails++; $display("FAIL rd_valid_cnt got %0d exp 1", vld_cnt); end
        tests++; if (vld_data !== 8'h53) begin fails++; $display("FAIL rd_data_at_valid got %h exp 53", vld_data); end
        tests++; if (vld_csb !== 1'b1)  begin fails++; $display("FAIL rd_valid_csb got %b exp 1", vld_csb); end
        tests++; if (rdd0 !== 8'h53)    begin fails++; $display("FAIL rd_data_hold got %h exp 53", rdd0); end
    endtask

    task automatic test_back_to_back();
        logic prev_csb;
        int   falls, hi_run, min_gap;
        @(negedge clk);
        wr0 = 1'b1; wd0 = 24'h112233;
        prev_csb = 1'b1; falls = 0; hi_run = 0; min_gap = 1000;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (csb0) hi_run++;
            else if (prev_csb) begin
                if (falls > 0 && hi_run < min_gap) min_gap = hi_run;
                falls++;
                hi_run = 0;
            end
            prev_csb = csb0;
        end
        wr0 = 1'b0;
        for (int i = 0; i < 400 && busy0; i++) @(negedge clk);
        tests++; if (falls != 3)   begin fails++; $display("FAIL b2b_frames got %0d exp 3", falls); end
        tests++; if (min_gap < 4)  begin fails++; $display("FAIL b2b_csb_gap got %0d exp >=4", min_gap); end
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL b2b_idle busy %b exp 0", busy0); end
        tests++; if (rdd0 !== 8'h53) begin fails++; $display("FAIL b2b_rd_data_kept got %h exp 53", rdd0); end

        slave_byte = 8'hA6;
        run_frame(1'b0, 1'b1, 1'b1, 24'h00C012);
        tests++; if (mosi[23:8] !== 16'hC012) begin fails++; $display("FAIL both_mosi got %h exp c012", mosi[23:8]); end
        tests++; if (oe_vec !== 24'hFFFF00) begin fails++; $display("FAIL both_oe got %h exp ffff00", oe_vec); end
        tests++; if (vld_cnt != 1 || vld_data !== 8'hA6) begin fails++; $display("FAIL both_read got %0d pulses data %h exp 1 a6", vld_cnt, vld_data); end
    endtask

    task automatic test_reset_mid();
        logic prev_sclk;
        int   n;
        @(negedge clk);
        wr0 = 1'b1; wd0 = 24'hFFFFFF;
        @(negedge clk);
        wr0 = 1'b0;
        prev_sclk = 1'b0; n = 0;
        for (int i = 0; i < 500 && n < 10; i++) begin
            if (sclk0 && !prev_sclk) n++;
            prev_sclk = sclk0;
            if (n < 10) @(negedge clk);
        end
        tests++; if (n != 10) begin fails++; $display("FAIL mid_rises got %0d exp 10", n); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if ({csb0, sclk0, busy0} !== 3'b100) begin fails++; $display("FAIL mid_reset csb,sclk,busy got %b exp 100", {csb0, sclk0, busy0}); end
        tests++; if (rdd0 !== 8'h00 || vld0 !== 1'b0) begin fails++; $display("FAIL mid_reset_rd got %h/%b exp 00/0", rdd0, vld0); end
        @(negedge clk);
        rst = 1'b0;
        run_frame(1'b0, 1'b1, 1'b0, 24'h3C1234);
        tests++; if (rises != 24 || busy_cnt != 200) begin fails++; $display("FAIL mid_next_frame got %0d rises %0d busy exp 24 200", rises, busy_cnt); end
        tests++; if (mosi !== 24'h12343C) begin fails++; $display("FAIL mid_next_mosi got %h exp 12343c", mosi); end
    endtask

    task automatic test_fast();
        slave_byte = 8'hFF;
        run_frame(1'b1, 1'b1, 1'b0, 24'h5A0010);
        tests++; if (busy_cnt != 99)  begin fails++; $display("FAIL fast_busy_len got %0d exp 99", busy_cnt); end
        tests++; if (rises != 24)     begin fails++; $display("FAIL fast_rises got %0d exp 24", rises); end
        tests++; if (mosi !== 24'h00105A) begin fails++; $display("FAIL fast_mosi got %h exp 00105a", mosi); end
        tests++; if (rise_cyc[1] - rise_cyc[0] != 4) begin fails++; $display("FAIL fast_sclk_period got %0d exp 4", rise_cyc[1] - rise_cyc[0]); end
        tests++; if (vld_cnt != 0)    begin fails++; $display("FAIL fast_rd_valid got %0d exp 0", vld_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ad9517_spi_master.md
Name: ad9517_spi_master

Overview:
- Downstream SPI engine for the AD9517 configuration sequencer; turns single-cycle write/read commands into one 24-bit AD9517 serial frame.
- Frame = 16-bit instruction + 8-bit data, SPI mode 0 (SCLK idles low, CSB active low).
- Returns the read byte and a busy flag, which the sequencer polls between commands.

Parameters:
- MOSI_DATA_WIDTH, 24, command/frame width in bits (fixed 24 for AD9517).
- MISO_DATA_WIDTH, 8, read-data width and length of the data phase.
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2).
- CS_IDLE, 4, minimum clk cycles CSB stays high between frames (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_spi_wr_cmd  in  1  write request
- i_spi_rd_cmd  in  1  read request
- i_spi_wr_data  in  MOSI_DATA_WIDTH  command word; [15:0] instruction (bit15=1 read), [23:16] write data
- o_spi_rd_data  out  MISO_DATA_WIDTH  last byte read
- o_spi_rd_valid  out  1  one-cycle pulse when o_spi_rd_data updates
- o_spi_busy  out  1  transfer in progress
- o_spi_sclk  out  1  serial clock
- o_spi_csb  out  1  chip select, active low
- o_spi_sdio  out  1  serial data out
- o_spi_sdio_oe  out  1  SDIO pad output enable (0 during read data phase)
- i_spi_miso  in  1  serial data in (SDO, or SDIO pad input in 3-wire mode)

Behaviour:
- Reset values: sclk=0, csb=1, sdio=0, sdio_oe=1, busy=0, rd_valid=0, rd_data=0. State returns to IDLE.
- Command acceptance:
  - Accepted only in IDLE when (wr_cmd|rd_cmd)=1.
  - i_spi_wr_data is latched on the accept cycle.
  - Read = rd_cmd on the accept cycle; if wr_cmd and rd_cmd are both high, the command is treated as a read.
  - Commands while busy=1 are ignored (no queue).
- Shift frame = {wr_data[15:0], wr_data[23:16]}, MSB first. Example: 24'h008003 shifts bytes 0x80, 0x03, 0x00.
- busy timing:
  - busy rises the cycle after accept; busy=0 on the accept cycle itself.
  - busy stays high through CS_GAP and drops when the state returns to IDLE.
- State machine: IDLE -> SETUP -> (HI -> LO) x24 -> CS_GAP -> IDLE.
  - SETUP (CLK_DIV cycles): csb=0, sclk=0, sdio=frame bit 23.
  - HI (CLK_DIV cycles): sclk=1. i_spi_miso sampled on the last cycle of HI.
  - LO (CLK_DIV cycles): sclk=0. The next frame bit is presented on the first LO cycle. The LO after bit 0 is the CSB hold; sdio=0 there.
  - CS_GAP (CS_IDLE cycles): csb=1, sclk=0, sdio=0.
- Counters:
  - Bit counter 5 bits, counts 23 down to 0.
  - Half-period counter ceil(log2(CLK_DIV)) bits, reloads each phase.
- Frame timing: exactly 24 SCLK rising edges per frame. busy high for CLK_DIV*49 + CS_IDLE cycles (200 at defaults).
- Read data path:
  - Only the last MISO_DATA_WIDTH sampled bits are kept, shifted into a capture register.
  - sdio_oe=0 from the LO following bit-8's HI through the final LO; 1 otherwise. Writes never drop sdio_oe.
  - On the first CS_GAP cycle after a read: o_spi_rd_data <= capture and rd_valid=1 for one cycle.
  - o_spi_rd_data holds until the next read completes; writes do not alter it.
- Reset mid-frame: on the next edge csb=1, sclk=0, busy=0, state IDLE, rd_data=0. No partial rd_valid.

Test Plan:
- Reset: rst high 3 cycles -> csb=1, sclk=0, busy=0, sdio_oe=1, rd_data=0x00.
- Write 24'h5A0010, one-cycle wr_cmd -> busy=1 from next cycle for 200 cycles. MOSI sampled at the 24 SCLK rises = 0x00, 0x10, 0x5A. sdio_oe stays 1. rd_valid never pulses.
- Read 24'h008003, slave model drives 0x53 on falling edges during the data phase -> MOSI = 0x80, 0x03, then don't-care. sdio_oe=0 for the last 8 bits. rd_data=0x53 with a one-cycle rd_valid at CSB rise.
- wr_cmd held high across a whole frame -> exactly one frame per IDLE visit; consecutive frames have CSB high >= CS_IDLE cycles. wr_cmd and rd_cmd both high -> read behaviour, oe drops.
- rst asserted after the 10th SCLK rise -> next cycle csb=1, sclk=0, busy=0. A following write runs a complete 24-bit frame.
- CLK_DIV=2, CS_IDLE=1 -> SCLK period 4 clk, busy duration 99 cycles, data correct as in the write test.
